// File: rtl/imu_pkg.sv
// Shared constants and state encoding for the IMU sequencer.
package imu_pkg;

  localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] WAKE_VALUE       = 8'h00;

  typedef enum logic [2:0] {
    StWakeIssue = 3'd0,
    StWakeWait  = 3'd1,
    StIdle      = 3'd2,
    StRdIssue   = 3'd3,
    StRdWait    = 3'd4,
    StPublish   = 3'd5
  } imu_state_e;

endpackage

// File: rtl/imu_tick_gen.sv
// Enable-gated sample-period counter; emits a one-cycle tick every SAMPLE_DIV cycles.
module imu_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt;

  // Count while running; hold at zero otherwise so the first tick is a full period away.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/imu_ctrl.sv
// IMU sequencer: wakes the sensor, then polls a burst of data registers per sample tick
// and publishes them as one big-endian frame.
module imu_ctrl
  import imu_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = 7'h68,
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter int unsigned TIMEOUT    = 65535,
  parameter logic [7:0]  BASE_REG   = REG_ACCEL_XOUT_H,
  parameter int unsigned NUM_BYTES  = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  output logic [6:0]               i2c_addr,
  output logic                     i2c_start,
  output logic                     i2c_rw,
  output logic [7:0]               i2c_reg,
  output logic [7:0]               i2c_wdata,
  input  logic [7:0]               i2c_rdata,
  input  logic                     i2c_busy,
  input  logic                     i2c_done,
  output logic [8*NUM_BYTES-1:0]   sample,
  output logic                     sample_valid,
  output logic                     ready,
  output logic                     overrun,
  output logic [7:0]               err_cnt
);

  localparam int unsigned IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  imu_state_e             state_q, state_d;
  logic [IW-1:0]          idx_q;
  logic [31:0]            tcnt_q;
  logic [8*NUM_BYTES-1:0] frame_q, frame_d;
  logic                   tick;
  logic                   issue_wake, issue_rd, in_wait, tout, last_byte;

  assign i2c_addr  = DEV_ADDR;
  assign last_byte = (idx_q == IW'(NUM_BYTES - 1));
  // A done arriving on the deadline cycle still counts as success.
  assign tout      = in_wait && !i2c_done && (tcnt_q == TIMEOUT);

  imu_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .run (ready && enable),
    .tick(tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StWakeIssue;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StWakeIssue: if (!i2c_busy) state_d = StWakeWait;
      StWakeWait: begin
        if (i2c_done)  state_d = StIdle;
        else if (tout) state_d = StWakeIssue;
      end
      StIdle:      if (tick) state_d = StRdIssue;
      StRdIssue:   if (!i2c_busy) state_d = StRdWait;
      StRdWait: begin
        if (i2c_done)  state_d = last_byte ? StPublish : StRdIssue;
        else if (tout) state_d = StIdle;
      end
      StPublish:   state_d = StIdle;
      default:     state_d = StWakeIssue;
    endcase
  end

  // State-decoded controls and the publish strobe.
  always_comb begin
    issue_wake   = 1'b0;
    issue_rd     = 1'b0;
    in_wait      = 1'b0;
    sample_valid = 1'b0;
    case (state_q)
      StWakeIssue: issue_wake   = !i2c_busy;
      StWakeWait:  in_wait      = 1'b1;
      StRdIssue:   issue_rd     = !i2c_busy;
      StRdWait:    in_wait      = 1'b1;
      StPublish:   sample_valid = 1'b1;
      default:     ;
    endcase
  end

  // Frame buffer with the byte being completed merged in.
  always_comb begin
    frame_d = frame_q;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (idx_q == IW'(b)) frame_d[8*(NUM_BYTES-1-b) +: 8] = i2c_rdata;
    end
  end

  // Transaction registers, timeout counter, frame capture and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      i2c_start <= 1'b0;
      i2c_rw    <= 1'b0;
      i2c_reg   <= 8'h00;
      i2c_wdata <= 8'h00;
      tcnt_q    <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      sample    <= '0;
      ready     <= 1'b0;
      overrun   <= 1'b0;
      err_cnt   <= 8'h00;
    end else begin
      i2c_start <= issue_wake || issue_rd;
      if (issue_wake) begin
        i2c_rw    <= 1'b0;
        i2c_reg   <= REG_PWR_MGMT_1;
        i2c_wdata <= WAKE_VALUE;
      end
      if (issue_rd) begin
        i2c_rw  <= 1'b1;
        i2c_reg <= BASE_REG + 8'(idx_q);
      end

      if (issue_wake || issue_rd) tcnt_q <= '0;
      else if (in_wait)           tcnt_q <= tcnt_q + 32'd1;

      if (state_q == StWakeWait && i2c_done) ready <= 1'b1;
      if (tout && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      if (state_q == StIdle && tick) idx_q <= '0;
      if (state_q == StRdWait && i2c_done) begin
        frame_q <= frame_d;
        // Publishing the merged frame here lets sample and sample_valid change together.
        if (last_byte) sample <= frame_d;
        else           idx_q  <= idx_q + 1'b1;
      end

      // Ticks outside IDLE are dropped, not queued.
      if (tick && state_q != StIdle) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imu_ctrl.sv
// Scoreboard bench for imu_ctrl driven by a behavioural I2C master model.
module tb_imu_ctrl;

  localparam int unsigned DIV = 300;
  localparam int unsigned TMO = 100;
  localparam int unsigned NB  = 14;

  typedef struct packed {
    logic       rw;
    logic [7:0] rg;
    logic [7:0] wd;
  } txn_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b0;
  logic [6:0]      i2c_addr;
  logic            i2c_start, i2c_rw;
  logic [7:0]      i2c_reg, i2c_wdata;
  logic [7:0]      i2c_rdata = 8'h00;
  logic            i2c_busy = 1'b0;
  logic            i2c_done = 1'b0;
  logic [8*NB-1:0] sample;
  logic            sample_valid, ready, overrun;
  logic [7:0]      err_cnt;

  imu_ctrl #(
    .DEV_ADDR  (7'h68),
    .SAMPLE_DIV(DIV),
    .TIMEOUT   (TMO),
    .BASE_REG  (8'h3B),
    .NUM_BYTES (NB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .i2c_addr    (i2c_addr),
    .i2c_start   (i2c_start),
    .i2c_rw      (i2c_rw),
    .i2c_reg     (i2c_reg),
    .i2c_wdata   (i2c_wdata),
    .i2c_rdata   (i2c_rdata),
    .i2c_busy    (i2c_busy),
    .i2c_done    (i2c_done),
    .sample      (sample),
    .sample_valid(sample_valid),
    .ready       (ready),
    .overrun     (overrun),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // I2C master model: busy for lat cycles after a start, then done with rdata = reg + offset.
  int         lat = 20;
  logic [7:0] offset = 8'h00;
  int         txn_no = 0;
  int         drop_txn = -1;
  int         m_left = 0;
  logic       m_drop = 1'b0;
  logic [7:0] m_reg = 8'h00;

  always @(negedge clk) begin
    i2c_done = 1'b0;
    if (rst) begin
      i2c_busy = 1'b0;
      m_left   = 0;
      txn_no   = 0;
    end else begin
      if (i2c_start) chk("no_start_while_busy", 128'(i2c_busy), 128'(0));
      if (i2c_busy) begin
        m_left--;
        if (m_left == 0) begin
          i2c_busy = 1'b0;
          if (!m_drop) begin
            i2c_done  = 1'b1;
            i2c_rdata = m_reg + offset;
          end
        end
      end
      if (i2c_start) begin
        txn_no++;
        i2c_busy = 1'b1;
        m_left   = lat;
        m_reg    = i2c_reg;
        m_drop   = (txn_no == drop_txn);
      end
    end
  end

  // Scoreboard.
  txn_t            exp_txn[$];
  logic [8*NB-1:0] exp_smp[$];
  int              n_txn = 0;
  int              n_smp = 0;
  int              last_start_cyc = 0;
  int              last_smp_cyc = 0;
  int              prev_smp_cyc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (i2c_start) begin
        txn_t t;
        n_txn++;
        last_start_cyc = cyc;
        if (exp_txn.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_txn: got rw=%0d reg=%0h expected none", i2c_rw, i2c_reg);
        end else begin
          t = exp_txn.pop_front();
          chk("txn_rw", 128'(i2c_rw), 128'(t.rw));
          chk("txn_reg", 128'(i2c_reg), 128'(t.rg));
          if (!t.rw) chk("txn_wdata", 128'(i2c_wdata), 128'(t.wd));
        end
      end
      if (sample_valid) begin
        n_smp++;
        prev_smp_cyc = last_smp_cyc;
        last_smp_cyc = cyc;
        if (exp_smp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_sample: got %0h expected none", sample);
        end else begin
          chk("sample", 128'(sample), 128'(exp_smp.pop_front()));
        end
      end
    end
  end

  function automatic logic [8*NB-1:0] frame_val(input logic [7:0] off);
    logic [8*NB-1:0] v = '0;
    for (int i = 0; i < NB; i++) v = {v[8*NB-9:0], 8'h3B + 8'(i) + off};
    return v;
  endfunction

  task automatic push_wake();
    exp_txn.push_back('{rw: 1'b0, rg: 8'h6B, wd: 8'h00});
  endtask

  task automatic push_reads(input int n);
    for (int i = 0; i < n; i++) exp_txn.push_back('{rw: 1'b1, rg: 8'h3B + 8'(i), wd: 8'h00});
  endtask

  task automatic push_frame(input logic [7:0] off);
    push_reads(NB);
    exp_smp.push_back(frame_val(off));
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("ready_in_time", 128'(ready), 128'(1));
  endtask

  task automatic wait_samples(input int target, input int budget);
    int n = 0;
    while (n_smp < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("samples_in_time", 128'(n_smp >= target), 128'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, 128'(i2c_start), 128'(0));
    chk({tag, "_rw"}, 128'(i2c_rw), 128'(0));
    chk({tag, "_reg"}, 128'(i2c_reg), 128'(0));
    chk({tag, "_wdata"}, 128'(i2c_wdata), 128'(0));
    chk({tag, "_sample"}, 128'(sample), 128'(0));
    chk({tag, "_valid"}, 128'(sample_valid), 128'(0));
    chk({tag, "_ready"}, 128'(ready), 128'(0));
    chk({tag, "_overrun"}, 128'(overrun), 128'(0));
    chk({tag, "_errcnt"}, 128'(err_cnt), 128'(0));
  endtask

  initial begin
    int base;
    int d;

    // Reset and a clean wake write with a 20-cycle master.
    repeat (4) @(negedge clk);
    chk_all_zero("reset");
    chk("dev_addr", 128'(i2c_addr), 128'(7'h68));
    push_wake();
    rst = 1'b0;
    wait_ready(200);
    d = cyc - last_start_cyc;
    chk("ready_latency_about_21", 128'(d >= 19 && d <= 23), 128'(1));
    chk("err_after_wake", 128'(err_cnt), 128'(0));

    // First wake write never acknowledged: one timeout, then a retry.
    rst = 1'b1;
    drop_txn = 1;
    repeat (3) @(negedge clk);
    push_wake();
    push_wake();
    rst = 1'b0;
    wait_ready(500);
    drop_txn = -1;
    chk("err_after_wake_retry", 128'(err_cnt), 128'(1));

    // Normal polling: two frames one period apart.
    lat = 5;
    offset = 8'h00;
    push_frame(8'h00);
    push_frame(8'h00);
    base = n_smp;
    enable = 1'b1;
    wait_samples(base + 2, 1500);
    enable = 1'b0;
    chk("period_normal", 128'(last_smp_cyc - prev_smp_cyc), 128'(DIV));
    chk("no_overrun_normal", 128'(overrun), 128'(0));

    // Timeout on the fifth read: frame dropped, old sample kept, next frame from 3B.
    offset = 8'h10;
    drop_txn = txn_no + 5;
    push_reads(5);
    push_frame(8'h10);
    base = n_smp;
    enable = 1'b1;
    d = 0;
    while (err_cnt != 8'd2 && d < 1000) begin
      @(negedge clk);
      d++;
    end
    chk("err_after_read_timeout", 128'(err_cnt), 128'(2));
    chk("sample_kept", 128'(sample), 128'(frame_val(8'h00)));
    wait_samples(base + 1, 1500);
    enable = 1'b0;
    drop_txn = -1;
    chk("no_overrun_timeout", 128'(overrun), 128'(0));

    // Frames longer than the period: overrun, every other tick used.
    lat = 25;
    offset = 8'h20;
    push_frame(8'h20);
    push_frame(8'h20);
    base = n_smp;
    enable = 1'b1;
    wait_samples(base + 2, 3000);
    enable = 1'b0;
    chk("overrun_set", 128'(overrun), 128'(1));
    chk("period_overrun", 128'(last_smp_cyc - prev_smp_cyc), 128'(2 * DIV));

    // Reset mid read: everything clears, wake precedes any read.
    lat = 20;
    offset = 8'h30;
    push_reads(1);
    base = n_txn;
    enable = 1'b1;
    d = 0;
    while (n_txn < base + 1 && d < 1000) begin
      @(negedge clk);
      d++;
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    push_wake();
    push_frame(8'h30);
    base = n_smp;
    @(negedge clk);
    rst = 1'b0;
    wait_samples(base + 1, 2000);
    enable = 1'b0;
    chk("err_after_rst", 128'(err_cnt), 128'(0));

    repeat (20) @(negedge clk);
    chk("txn_queue_empty", 128'(exp_txn.size()), 128'(0));
    chk("sample_queue_empty", 128'(exp_smp.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
